fog_mod_ramp_gen: RTL and testbench

FOG_MOD_RAMP_GEN -- requirements
Module: fog_mod_ramp_gen

---
 rtl/fog_mod_ramp_gen.sv | 121 ++++++++++++
 tb/tb_fog_mod_ramp_gen.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fog_mod_ramp_gen.sv
// Fiber-optic gyro modulation ramp generator: square-wave bias FSM with
// trigger/polarity outputs plus a closed-loop phase ramp summed into a DAC code.
module fog_mod_ramp_gen #(
  parameter int DAC_BIT = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic [31:0]         i_freq_cnt,
  input  logic signed [31:0]  i_mod_high,
  input  logic signed [31:0]  i_mod_low,
  input  logic signed [31:0]  i_step,
  input  logic                i_step_sync,
  input  logic                i_ramp_sync,
  input  logic [4:0]          i_gain_sel,
  output logic [DAC_BIT-1:0]  o_dac,
  output logic                o_polarity,
  output logic                o_trig,
  output logic [31:0]         o_ramp,
  output logic [1:0]          o_cstate
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN_L = 2'd2,
    RUN_H = 2'd3
  } state_t;

  state_t              cstate, nstate;
  logic                r_en;
  logic [31:0]         counter, counter_nxt;
  logic [31:0]         reload;
  logic                trig_q;
  logic signed [31:0]  r_step;
  logic [31:0]         ramp;
  logic [DAC_BIT-1:0]  bias;
  logic                unused_bits;

  assign unused_bits = ^{i_mod_high[31:DAC_BIT], i_mod_low[31:DAC_BIT]};

  // Half-period lengths below 2 are clamped to 2, so the reload is never 0-1.
  assign reload = (i_freq_cnt < 32'd2) ? 32'd1 : (i_freq_cnt - 32'd1);

  // State register; trig_q marks the first cycle spent in a newly entered RUN state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cstate  <= IDLE;
      counter <= '0;
      trig_q  <= 1'b0;
      r_en    <= 1'b0;
    end else begin
      cstate  <= nstate;
      counter <= counter_nxt;
      trig_q  <= (nstate != cstate) && ((nstate == RUN_L) || (nstate == RUN_H));
      r_en    <= i_en;
    end
  end

  always_comb begin
    nstate      = cstate;
    counter_nxt = counter;
    case (cstate)
      IDLE: begin
        counter_nxt = '0;
        if (r_en) nstate = LOAD;
      end
      LOAD: begin
        if (!r_en) begin
          nstate      = IDLE;
          counter_nxt = '0;
        end else begin
          nstate      = RUN_L;
          counter_nxt = reload;
        end
      end
      RUN_L, RUN_H: begin
        if (!r_en) begin
          nstate      = IDLE;
          counter_nxt = '0;
        end else if (counter == '0) begin
          nstate      = (cstate == RUN_L) ? RUN_H : RUN_L;
          counter_nxt = reload;
        end else begin
          counter_nxt = counter - 32'd1;
        end
      end
      default: begin
        nstate      = IDLE;
        counter_nxt = '0;
      end
    endcase
  end

  always_comb begin
    o_polarity = (cstate == RUN_H);
    o_trig     = trig_q;
    o_cstate   = cstate;
    o_ramp     = ramp;
    if (cstate == IDLE)
      bias = '0;
    else if (cstate == RUN_H)
      bias = i_mod_high[DAC_BIT-1:0];
    else
      bias = i_mod_low[DAC_BIT-1:0];
  end

  // Ramp reads the pre-update r_step when both strobes coincide; wrap is intentional.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_step <= '0;
      ramp   <= '0;
      o_dac  <= '0;
    end else begin
      if (i_step_sync) r_step <= i_step >>> i_gain_sel;
      if (i_ramp_sync) ramp <= ramp + $unsigned(r_step);
      o_dac <= ramp[31:32-DAC_BIT] + bias;
    end
  end

endmodule

// File: tb/tb_fog_mod_ramp_gen.sv
// Directed self-checking bench for fog_mod_ramp_gen.
module tb_fog_mod_ramp_gen;

  logic               i_clk = 1'b0;
  logic               i_rst_n;
  logic               i_en;
  logic [31:0]        i_freq_cnt;
  logic signed [31:0] i_mod_high;
  logic signed [31:0] i_mod_low;
  logic signed [31:0] i_step;
  logic               i_step_sync;
  logic               i_ramp_sync;
  logic [4:0]         i_gain_sel;
  logic [15:0]        o_dac;
  logic               o_polarity;
  logic               o_trig;
  logic [31:0]        o_ramp;
  logic [1:0]         o_cstate;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 i_clk = ~i_clk;

  fog_mod_ramp_gen #(.DAC_BIT(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_freq_cnt(i_freq_cnt),
    .i_mod_high(i_mod_high), .i_mod_low(i_mod_low), .i_step(i_step),
    .i_step_sync(i_step_sync), .i_ramp_sync(i_ramp_sync), .i_gain_sel(i_gain_sel),
    .o_dac(o_dac), .o_polarity(o_polarity), .o_trig(o_trig),
    .o_ramp(o_ramp), .o_cstate(o_cstate)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_en = 1'b0; i_freq_cnt = 32'd10;
    i_mod_high = 32'sh200; i_mod_low = 32'sh100; i_step = '0;
    i_step_sync = 1'b0; i_ramp_sync = 1'b0; i_gain_sel = '0;
    tick(); tick();
    n_cmp++; if ({o_cstate, o_trig, o_polarity} !== 4'b0000) begin n_err++;
      $display("FAIL reset_ctrl got st=%0d trig=%0b pol=%0b want 0/0/0", o_cstate, o_trig, o_polarity); end
    n_cmp++; if (o_dac !== 16'h0) begin n_err++; $display("FAIL reset_dac got %h want 0000", o_dac); end
    n_cmp++; if (o_ramp !== 32'h0) begin n_err++; $display("FAIL reset_ramp got %h want 0", o_ramp); end
    i_rst_n = 1'b1;
    tick();
    n_cmp++; if (o_cstate !== 2'd0) begin n_err++; $display("FAIL idle_hold got st=%0d want 0", o_cstate); end
  endtask

  task automatic test_basic_period();
    logic       ep, et;
    logic [15:0] ed;
    i_freq_cnt = 32'd10; i_en = 1'b1;
    tick();
    n_cmp++; if ({o_cstate, o_trig} !== 3'b000) begin n_err++;
      $display("FAIL start_idle got st=%0d trig=%0b want 0/0", o_cstate, o_trig); end
    tick();
    n_cmp++; if ({o_cstate, o_trig} !== 3'b010) begin n_err++;
      $display("FAIL start_load got st=%0d trig=%0b want 1/0", o_cstate, o_trig); end
    tick();
    for (int t = 0; t < 35; t++) begin
      if (t > 0) tick();
      ep = ((t / 10) % 2) == 1;
      et = (t % 10) == 0;
      ed = (t == 0) ? 16'h100 : ((((t - 1) / 10) % 2) == 1 ? 16'h200 : 16'h100);
      n_cmp++; if (o_trig !== et) begin n_err++; $display("FAIL period_trig t=%0d got %0b want %0b", t, o_trig, et); end
      n_cmp++; if (o_polarity !== ep) begin n_err++; $display("FAIL period_pol t=%0d got %0b want %0b", t, o_polarity, ep); end
      n_cmp++; if (o_cstate !== (ep ? 2'd3 : 2'd2)) begin n_err++;
        $display("FAIL period_state t=%0d got %0d want %0d", t, o_cstate, ep ? 3 : 2); end
      n_cmp++; if (o_dac !== ed) begin n_err++; $display("FAIL period_dac t=%0d got %h want %h", t, o_dac, ed); end
    end
    i_en = 1'b0;
    tick();
    n_cmp++; if ({o_cstate, o_trig, o_polarity} !== 4'b1101) begin n_err++;
      $display("FAIL drop_en_h got st=%0d trig=%0b pol=%0b want 3/0/1", o_cstate, o_trig, o_polarity); end
    tick();
    n_cmp++; if ({o_cstate, o_trig, o_polarity} !== 4'b0000) begin n_err++;
      $display("FAIL drop_en_idle got st=%0d trig=%0b pol=%0b want 0/0/0", o_cstate, o_trig, o_polarity); end
    n_cmp++; if (o_dac !== 16'h200) begin n_err++; $display("FAIL drop_en_dac_lag got %h want 0200", o_dac); end
    tick();
    n_cmp++; if (o_dac !== 16'h0) begin n_err++; $display("FAIL idle_dac_nobias got %h want 0000", o_dac); end
    n_cmp++; if ({o_cstate, o_trig} !== 3'b000) begin n_err++;
      $display("FAIL idle_stay got st=%0d trig=%0b want 0/0", o_cstate, o_trig); end
  endtask

  task automatic test_min_freq();
    logic ep, et;
    i_freq_cnt = 32'd0; i_en = 1'b1;
    tick(); tick(); tick();
    for (int t = 0; t < 24; t++) begin
      if (t > 0) tick();
      et = (t % 2) == 0;
      ep = ((t / 2) % 2) == 1;
      n_cmp++; if (o_trig !== et) begin n_err++; $display("FAIL minf_trig t=%0d got %0b want %0b", t, o_trig, et); end
      n_cmp++; if (o_polarity !== ep) begin n_err++; $display("FAIL minf_pol t=%0d got %0b want %0b", t, o_polarity, ep); end
      if (t == 11) i_freq_cnt = 32'd1;
    end
    i_en = 1'b0;
    tick(); tick();
    n_cmp++; if ({o_cstate, o_trig} !== 3'b000) begin n_err++;
      $display("FAIL minf_stop got st=%0d trig=%0b want 0/0", o_cstate, o_trig); end
  endtask

  task automatic test_freq_change();
    logic ep, et;
    i_freq_cnt = 32'd4; i_en = 1'b1;
    tick(); tick(); tick();
    for (int t = 0; t < 12; t++) begin
      if (t > 0) tick();
      et = (t == 0) || (t == 4) || (t == 10);
      ep = (t >= 4) && (t < 10);
      n_cmp++; if (o_trig !== et) begin n_err++; $display("FAIL fchg_trig t=%0d got %0b want %0b", t, o_trig, et); end
      n_cmp++; if (o_polarity !== ep) begin n_err++; $display("FAIL fchg_pol t=%0d got %0b want %0b", t, o_polarity, ep); end
      if (t == 1) i_freq_cnt = 32'd6;
    end
    i_en = 1'b0;
    tick(); tick();
    n_cmp++; if (o_cstate !== 2'd0) begin n_err++; $display("FAIL fchg_stop got st=%0d want 0", o_cstate); end
  endtask

  task automatic test_ramp_wrap();
    logic [31:0] exp_r [4] = '{32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 32'h0000_0000};
    i_step = 32'sh4000_0000; i_gain_sel = 5'd0; i_step_sync = 1'b1;
    tick();
    i_step_sync = 1'b0;
    n_cmp++; if (o_ramp !== 32'h0) begin n_err++; $display("FAIL wrap_no_move got %h want 0", o_ramp); end
    i_ramp_sync = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if (o_ramp !== exp_r[k]) begin n_err++; $display("FAIL wrap_ramp k=%0d got %h want %h", k, o_ramp, exp_r[k]); end
      if (k > 0) begin
        n_cmp++; if (o_dac !== exp_r[k-1][31:16]) begin n_err++;
          $display("FAIL wrap_dac k=%0d got %h want %h", k, o_dac, exp_r[k-1][31:16]); end
      end
    end
    i_ramp_sync = 1'b0;
    tick();
    n_cmp++; if (o_ramp !== 32'h0) begin n_err++; $display("FAIL wrap_hold got %h want 0", o_ramp); end
    n_cmp++; if (o_dac !== 16'h0) begin n_err++; $display("FAIL wrap_dac_end got %h want 0000", o_dac); end
  endtask

  task automatic test_neg_step();
    logic [31:0] e;
    i_step = -32'sd256; i_gain_sel = 5'd4; i_step_sync = 1'b1;
    tick();
    i_step_sync = 1'b0; i_ramp_sync = 1'b1;
    for (int unsigned k = 1; k <= 3; k++) begin
      tick();
      e = 32'd0 - (32'd16 * k);
      n_cmp++; if (o_ramp !== e) begin n_err++; $display("FAIL neg_ramp k=%0d got %h want %h", k, o_ramp, e); end
    end
    i_ramp_sync = 1'b0;
  endtask

  task automatic test_back_to_back();
    i_step = 32'sd5; i_gain_sel = 5'd0; i_step_sync = 1'b1;
    tick();
    i_step_sync = 1'b0;
    tick();
    n_cmp++; if (o_ramp !== 32'hFFFF_FFD0) begin n_err++; $display("FAIL b2b_pre got %h want ffffffd0", o_ramp); end
    i_step = 32'sd100; i_step_sync = 1'b1; i_ramp_sync = 1'b1;
    tick();
    i_step_sync = 1'b0;
    n_cmp++; if (o_ramp !== 32'hFFFF_FFD5) begin n_err++; $display("FAIL b2b_old_step got %h want ffffffd5", o_ramp); end
    tick();
    i_ramp_sync = 1'b0;
    n_cmp++; if (o_ramp !== 32'h0000_0039) begin n_err++; $display("FAIL b2b_new_step got %h want 00000039", o_ramp); end
    tick();
    n_cmp++; if (o_ramp !== 32'h0000_0039) begin n_err++; $display("FAIL b2b_hold got %h want 00000039", o_ramp); end
  endtask

  task automatic test_reset_mid();
    i_freq_cnt = 32'd10; i_en = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    n_cmp++; if (o_cstate !== 2'd2) begin n_err++; $display("FAIL rmid_pre got st=%0d want 2", o_cstate); end
    #1 i_rst_n = 1'b0;
    #1;
    n_cmp++; if ({o_cstate, o_trig, o_polarity} !== 4'b0000) begin n_err++;
      $display("FAIL rmid_async got st=%0d trig=%0b pol=%0b want 0/0/0", o_cstate, o_trig, o_polarity); end
    n_cmp++; if ({o_ramp, o_dac} !== 48'h0) begin n_err++;
      $display("FAIL rmid_data got ramp=%h dac=%h want 0/0", o_ramp, o_dac); end
    tick(); tick();
    i_rst_n = 1'b1;
    tick();
    n_cmp++; if ({o_cstate, o_trig} !== 3'b000) begin n_err++;
      $display("FAIL rel_c1 got st=%0d trig=%0b want 0/0", o_cstate, o_trig); end
    tick();
    n_cmp++; if ({o_cstate, o_trig} !== 3'b010) begin n_err++;
      $display("FAIL rel_c2 got st=%0d trig=%0b want 1/0", o_cstate, o_trig); end
    tick();
    n_cmp++; if ({o_cstate, o_trig, o_polarity} !== 4'b1010) begin n_err++;
      $display("FAIL rel_c3 got st=%0d trig=%0b pol=%0b want 2/1/0", o_cstate, o_trig, o_polarity); end
    tick();
    n_cmp++; if (o_trig !== 1'b0) begin n_err++; $display("FAIL rel_c4 got trig=%0b want 0", o_trig); end
    i_en = 1'b0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_basic_period();
    test_min_freq();
    test_freq_change();
    test_ramp_wrap();
    test_neg_step();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
